// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace capture buffer.
package wb_trace_pkg;

  // Default record widths; the top module may override them via its own parameters.
  localparam int TRACE_XLEN  = 32;
  localparam int TRACE_SEQ_W = 16;

  // Full-buffer policy selected by the wrap_mode input.
  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // One captured retirement. The destination register field is named rd
  // because reg is a reserved word.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic                   ena;
    logic [4:0]             rd;
    logic [TRACE_XLEN-1:0]  value;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_rec_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Writeback trace bus: producer side (wb_*) and reader side (out_*).
interface wb_trace_fifo_if #(
  parameter int XLEN  = 32,
  parameter int SEQ_W = 16
);

  logic             wb_have_inst;
  logic [XLEN-1:0]  wb_pc;
  logic             wb_ena;
  logic [4:0]       wb_reg;
  logic [XLEN-1:0]  wb_value;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic             out_ena;
  logic [4:0]       out_reg;
  logic [XLEN-1:0]  out_value;
  logic [SEQ_W-1:0] out_seq;

  // Environment: drives the core's retirement stream and the reader's ready.
  modport master (
    output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    input  out_valid, out_pc, out_ena, out_reg, out_value, out_seq
  );

  // Trace buffer: consumes the retirement stream and presents the head record.
  modport slave (
    input  wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    output out_valid, out_pc, out_ena, out_reg, out_value, out_seq
  );

endinterface

// File: rtl/wb_trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the controller.
module wb_trace_ram
  import wb_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  AW    = clog2(DEPTH),
  parameter type rec_t = trace_rec_t
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rec_t          wdata,
  input  logic [AW-1:0] raddr,
  output rec_t          rdata
);

  rec_t mem [DEPTH];

  // Write the incoming record into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Capture buffer for the CPU writeback trace: numbers every commit, optionally
// keeps only register writes, and either stops or overwrites the oldest entry
// when full, counting every record that is lost.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   wrap_mode,
  input  logic                   filter_wr,
  wb_trace_fifo_if.slave         bus,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic             ena;
    logic [4:0]       rd;
    logic [XLEN-1:0]  value;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  // Lost-record counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]    count_nx;
  logic [CNT_W-1:0] drop_nx;
  logic [SEQ_W-1:0] seq, seq_nx;
  logic             commit, push, pop, valid, is_full, ram_we;
  rec_t             wr_rec, rd_rec;

  assign valid   = (count != '0);
  assign is_full = (count == CW'(DEPTH));
  assign commit  = enable & bus.wb_have_inst;
  assign push    = commit & (~filter_wr | (bus.wb_ena & (bus.wb_reg != 5'd0)));
  assign pop     = valid & bus.out_ready;

  assign wr_rec = '{pc: bus.wb_pc, ena: bus.wb_ena, rd: bus.wb_reg,
                    value: bus.wb_value, seq: seq};

  // Next-state for pointers, occupancy, sequence and drop counter.
  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count;
    drop_nx   = drop_cnt;
    ram_we    = 1'b0;
    seq_nx    = commit ? seq + SEQ_W'(1) : seq;

    if (!is_full) begin
      if (push) begin
        ram_we    = 1'b1;
        wr_ptr_nx = wr_ptr + AW'(1);
      end
      if (pop) rd_ptr_nx = rd_ptr + AW'(1);
      count_nx = count + CW'(push) - CW'(pop);
    end else if (push && pop) begin
      // Full with a concurrent read: the freed head slot takes the new record.
      ram_we    = 1'b1;
      wr_ptr_nx = wr_ptr + AW'(1);
      rd_ptr_nx = rd_ptr + AW'(1);
    end else if (push) begin
      case (wrap_mode)
        MODE_STOP: drop_nx = sat_inc(drop_cnt);
        MODE_WRAP: begin
          // Overwrite the oldest record; the head advances past it.
          ram_we    = 1'b1;
          wr_ptr_nx = wr_ptr + AW'(1);
          rd_ptr_nx = rd_ptr + AW'(1);
          drop_nx   = sat_inc(drop_cnt);
        end
        default: ;
      endcase
    end else if (pop) begin
      rd_ptr_nx = rd_ptr + AW'(1);
      count_nx  = count - CW'(1);
    end

    // Flush discards any push/pop of this cycle; the commit numbering carries on.
    if (clear) begin
      ram_we    = 1'b0;
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      count_nx  = '0;
      drop_nx   = '0;
    end
  end

  // Control state register; reset overrides clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      seq      <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      drop_cnt <= drop_nx;
      seq      <= seq_nx;
    end
  end

  wb_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .rec_t (rec_t)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (rd_rec)
  );

  // Head data is forced to zero while empty, so stale storage never shows.
  assign full          = is_full;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? rd_rec.pc    : '0;
  assign bus.out_ena   = valid ? rd_rec.ena   : 1'b0;
  assign bus.out_reg   = valid ? rd_rec.rd    : '0;
  assign bus.out_value = valid ? rd_rec.value : '0;
  assign bus.out_seq   = valid ? rd_rec.seq   : '0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo (DEPTH=4): stimulus pushes hand-computed
// records into a queue, a monitor pops and compares on every accepted head.
module tb_wb_trace_fifo;

  logic       clk = 1'b0;
  logic       reset, clear, enable, wrap_mode, filter_wr;
  logic [2:0] count;
  logic       full;
  logic [7:0] drop_cnt;

  wb_trace_fifo_if #(.XLEN(32), .SEQ_W(16)) bus ();

  wb_trace_fifo #(
    .XLEN(32), .DEPTH(4), .SEQ_W(16), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .enable    (enable),
    .wrap_mode (wrap_mode),
    .filter_wr (filter_wr),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [15:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [31:0] pc, input logic ena, input logic [4:0] rd,
                            input logic [31:0] value, input logic [15:0] seq);
    exp_t e;
    e.pc = pc; e.ena = ena; e.rd = rd; e.value = value; e.seq = seq;
    exp_q.push_back(e);
  endtask

  task automatic commit(input logic [31:0] pc, input logic ena, input logic [4:0] rd,
                        input logic [31:0] value);
    bus.wb_have_inst = 1'b1;
    bus.wb_pc        = pc;
    bus.wb_ena       = ena;
    bus.wb_reg       = rd;
    bus.wb_value     = value;
    tick();
    bus.wb_have_inst = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; bus.wb_have_inst = 1'b0; bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && count != 3'd0; i++) tick();
    bus.out_ready = 1'b0;
    check("drain_done", 32'(count), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every head accepted by the reader must match the queue front.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got seq=%0d pc=0x%0h, expected no record", bus.out_seq, bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_ena !== e.ena || bus.out_reg !== e.rd ||
            bus.out_value !== e.value || bus.out_seq !== e.seq) begin
          errors++;
          $display("FAIL record: got pc=0x%0h ena=%0b reg=%0d value=0x%0h seq=%0d expected pc=0x%0h ena=%0b reg=%0d value=0x%0h seq=%0d",
                   bus.out_pc, bus.out_ena, bus.out_reg, bus.out_value, bus.out_seq,
                   e.pc, e.ena, e.rd, e.value, e.seq);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1; wrap_mode = 1'b0; filter_wr = 1'b0;
    bus.wb_pc = '0; bus.wb_ena = 1'b0; bus.wb_reg = '0; bus.wb_value = '0;
    do_reset();

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_seq", 32'(bus.out_seq), 32'd0);

    // Three commits, no reader: head visible one cycle after the first push
    commit(32'h0, 1'b1, 5'd1, 32'h1000);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_pc", bus.out_pc, 32'h0);
    commit(32'h4, 1'b1, 5'd2, 32'h1004);
    commit(32'h8, 1'b1, 5'd3, 32'h1008);
    check("t1_count", 32'(count), 32'd3);
    check("t1_head_pc", bus.out_pc, 32'h0);
    check("t1_head_seq", 32'(bus.out_seq), 32'd0);
    expect_rec(32'h0, 1'b1, 5'd1, 32'h1000, 16'd0);
    expect_rec(32'h4, 1'b1, 5'd2, 32'h1004, 16'd1);
    expect_rec(32'h8, 1'b1, 5'd3, 32'h1008, 16'd2);
    drain();

    // Write-only filter: only the third commit qualifies, seq still counts all three
    do_reset();
    filter_wr = 1'b1;
    commit(32'h10, 1'b1, 5'd0, 32'h11);
    commit(32'h14, 1'b0, 5'd5, 32'h22);
    commit(32'h18, 1'b1, 5'd5, 32'h2A);
    filter_wr = 1'b0;
    check("flt_count", 32'(count), 32'd1);
    check("flt_reg", 32'(bus.out_reg), 32'd5);
    check("flt_value", bus.out_value, 32'h2A);
    check("flt_seq", 32'(bus.out_seq), 32'd2);
    expect_rec(32'h18, 1'b1, 5'd5, 32'h2A, 16'd2);
    drain();

    // Stop mode: 6 commits into 4 slots keep the first 4
    do_reset();
    wrap_mode = 1'b0;
    for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
    check("stop_count", 32'(count), 32'd4);
    check("stop_full", 32'(full), 32'd1);
    check("stop_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) expect_rec(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 16'(i));
    drain();

    // Wrap mode: 6 commits into 4 slots keep the last 4
    do_reset();
    wrap_mode = 1'b1;
    for (int i = 0; i < 6; i++) commit(32'h180 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hB0 + 32'(i));
    check("wrap_count", 32'(count), 32'd4);
    check("wrap_drop", 32'(drop_cnt), 32'd2);
    check("wrap_head_seq", 32'(bus.out_seq), 32'd2);
    check("wrap_head_pc", bus.out_pc, 32'h188);
    for (int i = 2; i < 6; i++) expect_rec(32'h180 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hB0 + 32'(i), 16'(i));
    drain();
    wrap_mode = 1'b0;

    // Full with push and pop every cycle: nothing dropped, sequence contiguous
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit(32'h200 + 32'(4 * i), 1'b1, 5'd7, 32'hC0 + 32'(i));
      expect_rec(32'h200 + 32'(4 * i), 1'b1, 5'd7, 32'hC0 + 32'(i), 16'(i));
    end
    bus.out_ready = 1'b1;
    for (int i = 4; i < 14; i++) begin
      expect_rec(32'h200 + 32'(4 * i), 1'b1, 5'd7, 32'hC0 + 32'(i), 16'(i));
      commit(32'h200 + 32'(4 * i), 1'b1, 5'd7, 32'hC0 + 32'(i));
      check("pp_count", 32'(count), 32'd4);
    end
    check("pp_drop", 32'(drop_cnt), 32'd0);
    drain();

    // Clear with 3 entries: empties next cycle, numbering continues
    do_reset();
    for (int i = 0; i < 3; i++) commit(32'h300 + 32'(4 * i), 1'b1, 5'd9, 32'hD0 + 32'(i));
    check("clr_pre_count", 32'(count), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    commit(32'h400, 1'b1, 5'd10, 32'hE0);
    check("clr_next_seq", 32'(bus.out_seq), 32'd3);
    expect_rec(32'h400, 1'b1, 5'd10, 32'hE0, 16'd3);
    drain();

    // Drop counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 304; i++) commit(32'h500, 1'b1, 5'd1, 32'h1);
    check("sat_drop", 32'(drop_cnt), 32'hFF);
    check("sat_count", 32'(count), 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("sat_clr_drop", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
